deep_task_arbiter: RTL
======================

Name: deep_task_arbiter

Overview:
- Two-requester round-robin scheduler that shares one multi-cycle action unit.
- The action unit performs the select-op compute followed by a low-bit post-adjust.
- Each requester presents operands and an action over a valid/ready handshake.
- The block grants one requester, sequences the unit through compute and adjust states, and returns the tagged result over a valid/ready response port.
- It sits between the requester front-ends and downstream result consumers.

Parameters:
- WIDTH, 8, operand and result width.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- dta_clk  input  1  clock; all state updates on the rising edge.
- dta_rst  input  1  synchronous, active-high reset.
- dta_req0_valid  input  1  requester 0 has a transaction.
- dta_req0_ready  output  1  requester 0 transaction accepted this cycle.
- dta_req0_a  input  WIDTH  requester 0 operand A.
- dta_req0_b  input  WIDTH  requester 0 operand B.
- dta_req0_action  input  2  requester 0 action select.
- dta_req1_valid, dta_req1_ready, dta_req1_a, dta_req1_b, dta_req1_action: same as requester 0, for requester 1.
- dta_rsp_valid  output  1  result available.
- dta_rsp_ready  input  1  consumer accepts result.
- dta_rsp_data  output  WIDTH  result.
- dta_rsp_id  output  1  index of the requester that owns the result.
- dta_busy  output  1  FSM not in IDLE.
- dta_done_cnt  output  CNT_W  completed responses, wraps modulo 2^CNT_W.

Behaviour:
- FSM states: IDLE -> CALC -> ADJ -> OUT -> IDLE. All registers update on the rising edge of dta_clk.
- Reset: state=IDLE, dta_rsp_valid=0, dta_rsp_data=0, dta_rsp_id=0, dta_done_cnt=0, last_grant=1 (so requester 0 wins first). Operand registers are cleared.
- Reset mid-operation: the in-flight transaction is dropped and no response is produced. Reset overrides all other events in the same cycle.
- IDLE grant selection:
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the requester that is not last_grant.
  - dta_reqN_ready is combinational: 1 only for the granted requester, only in IDLE, and only when its valid is high.
- Handshake (valid & ready): capture a, b, action and id; update last_grant to the granted index; go to CALC.
- Outside IDLE, both ready outputs are 0. A requester may drop valid before it is granted; nothing happens in that case.
- CALC: temp <= op(a, b), all results modulo 2^WIDTH.
  - action[0]=1, action[1]=1: a+b.
  - action[0]=1, action[1]=0: a-b.
  - action[0]=0, action[1]=1: a&b.
  - action[0]=0, action[1]=0: a|b.
- ADJ: select on temp[1:0], result modulo 2^WIDTH.
  - 00: ~temp.
  - 01: temp+1.
  - 10: temp-1.
  - 11: temp.
- ADJ then registers the result into dta_rsp_data, sets dta_rsp_id, sets dta_rsp_valid=1, and moves to OUT.
- Latency: request handshake in cycle T gives dta_rsp_valid=1 in cycle T+3.
- OUT:
  - dta_rsp_valid, dta_rsp_data and dta_rsp_id are held stable until dta_rsp_ready=1.
  - On the response handshake: dta_rsp_valid<=0, dta_done_cnt<=dta_done_cnt+1 (wrapping), go to IDLE.
- No overlap between transactions: the next grant comes no earlier than the cycle after the response handshake. Peak throughput is 1 transaction per 4 cycles.
- dta_busy = (state != IDLE), decoded from the state register.
- Undefined state encodings recover to IDLE.

Test Plan:
- Reset, then req0 a=0x05 b=0x03 action=2'b11 -> sum 0x08, adjust 00 gives dta_rsp_data=0xF7, dta_rsp_id=0, valid at T+3; dta_done_cnt=1 after the response handshake.
- req1 only, a=0x05 b=0x07 action=2'b01 -> 0xFE, adjust 10 gives 0xFD, id=1. req0_ready must stay 0 throughout.
- Both valid right after reset: req0 a=0x0C b=0x0A action=2'b00 and req1 a=0x0F b=0x05 action=2'b10 (both held valid).
  - First response: 0x0D, id 0.
  - Second response: 0x06, id 1.
  - With both still valid, grants keep alternating 0,1,0,1.
- dta_rsp_ready held low for 5 cycles in OUT -> data, id and valid stay stable; both req ready outputs stay 0; dta_busy=1; dta_done_cnt is unchanged until the ready pulse.
- dta_rst asserted while in ADJ -> next cycle: IDLE, dta_rsp_valid=0, dta_busy=0, no response for the dropped request. With both requesters valid, requester 0 is granted first.
- 256 back-to-back transactions with dta_rsp_ready=1 -> dta_done_cnt wraps to 0x00; each response appears exactly 3 cycles after its grant.

Source files
------------

// File: rtl/deep_task_arbiter.sv
// deep_task_arbiter: two-requester round-robin front end sharing one
// multi-cycle compute/adjust unit, with a tagged valid/ready response port.
module deep_task_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             dta_clk,
    input  logic             dta_rst,
    input  logic             dta_req0_valid,
    output logic             dta_req0_ready,
    input  logic [WIDTH-1:0] dta_req0_a,
    input  logic [WIDTH-1:0] dta_req0_b,
    input  logic [1:0]       dta_req0_action,
    input  logic             dta_req1_valid,
    output logic             dta_req1_ready,
    input  logic [WIDTH-1:0] dta_req1_a,
    input  logic [WIDTH-1:0] dta_req1_b,
    input  logic [1:0]       dta_req1_action,
    output logic             dta_rsp_valid,
    input  logic             dta_rsp_ready,
    output logic [WIDTH-1:0] dta_rsp_data,
    output logic             dta_rsp_id,
    output logic             dta_busy,
    output logic [CNT_W-1:0] dta_done_cnt
);

    // Three-bit encoding leaves spare codes; any of them falls back to IDLE.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_ADJ  = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;

    localparam logic [WIDTH-1:0] L_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] L_CNT_1 = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_action;
    logic             r_id;
    logic [WIDTH-1:0] r_temp;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_id;
    logic [CNT_W-1:0] r_done_cnt;

    logic             w_idle;
    logic             w_grant_vld;
    logic             w_grant;
    logic             w_req_fire;
    logic             w_rsp_fire;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [1:0]       w_sel_action;
    logic [WIDTH-1:0] w_calc;
    logic [WIDTH-1:0] w_adj;

    // Grants are only offered from IDLE and never while reset is applied.
    assign w_idle = (r_state == S_IDLE) && !dta_rst;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = 1'b0;
        if (dta_req0_valid && dta_req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant     = ~r_last_grant;
        end else if (dta_req0_valid) begin
            w_grant_vld = 1'b1;
            w_grant     = 1'b0;
        end else if (dta_req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant     = 1'b1;
        end
    end

    assign dta_req0_ready = w_idle && w_grant_vld && !w_grant;
    assign dta_req1_ready = w_idle && w_grant_vld && w_grant;

    assign w_req_fire = dta_req0_ready || dta_req1_ready;
    assign w_rsp_fire = (r_state == S_OUT) && r_rsp_valid && dta_rsp_ready;

    assign w_sel_a      = w_grant ? dta_req1_a      : dta_req0_a;
    assign w_sel_b      = w_grant ? dta_req1_b      : dta_req0_b;
    assign w_sel_action = w_grant ? dta_req1_action : dta_req0_action;

    // Select-op compute; all arithmetic wraps at WIDTH bits.
    always_comb begin
        w_calc = '0;
        unique case (r_action)
            2'b11:   w_calc = r_a + r_b;
            2'b01:   w_calc = r_a - r_b;
            2'b10:   w_calc = r_a & r_b;
            default: w_calc = r_a | r_b;
        endcase
    end

    // Post-adjust steered by the two low bits of the compute result.
    always_comb begin
        w_adj = '0;
        unique case (r_temp[1:0])
            2'b00:   w_adj = ~r_temp;
            2'b01:   w_adj = r_temp + L_ONE;
            2'b10:   w_adj = r_temp - L_ONE;
            default: w_adj = r_temp;
        endcase
    end

    // Next-state decode for the IDLE -> CALC -> ADJ -> OUT loop.
    always_comb begin
        w_next_state = S_IDLE;
        unique case (r_state)
            S_IDLE:  w_next_state = w_req_fire ? S_CALC : S_IDLE;
            S_CALC:  w_next_state = S_ADJ;
            S_ADJ:   w_next_state = S_OUT;
            S_OUT:   w_next_state = w_rsp_fire ? S_IDLE : S_OUT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge dta_clk) begin
        if (dta_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the granted request and remember who was served.
    always_ff @(posedge dta_clk) begin
        if (dta_rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_action     <= 2'b00;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_req_fire) begin
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            r_action     <= w_sel_action;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
        end
    end

    // Intermediate compute result, loaded in CALC.
    always_ff @(posedge dta_clk) begin
        if (dta_rst) begin
            r_temp <= '0;
        end else if (r_state == S_CALC) begin
            r_temp <= w_calc;
        end
    end

    // Response register: loaded in ADJ, held through OUT until accepted.
    always_ff @(posedge dta_clk) begin
        if (dta_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= 1'b0;
        end else if (r_state == S_ADJ) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_adj;
            r_rsp_id    <= r_id;
        end else if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Completed-response counter, wrapping naturally at CNT_W bits.
    always_ff @(posedge dta_clk) begin
        if (dta_rst) begin
            r_done_cnt <= '0;
        end else if (w_rsp_fire) begin
            r_done_cnt <= r_done_cnt + L_CNT_1;
        end
    end

    assign dta_rsp_valid = r_rsp_valid;
    assign dta_rsp_data  = r_rsp_data;
    assign dta_rsp_id    = r_rsp_id;
    assign dta_busy      = (r_state != S_IDLE);
    assign dta_done_cnt  = r_done_cnt;

endmodule
